// File: rtl/sipo_ctrl.sv
// Sequencing controller for a WIDTH-bit SIPO shift chain: clear, WIDTH shifts, capture, valid/ready hand-off.
// Optional sticky overrun flag enabled by defining SIPO_CTRL_OVERRUN_EN.
//
// state   | meaning
// IDLE    | waiting for start
// CLR     | one cycle clearing the shift chain, bit counter loads 0
// SHIFT   | chain shifts one bit per cycle, WIDTH cycles total
// CAPTURE | parallel chain outputs latched into data_out at end of cycle
// HOLD    | word offered downstream until data_ready
module sipo_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    output logic             busy,
    output logic             sipo_clear_n,
    output logic             sipo_shift_en,
    input  logic [WIDTH-1:0] sipo_q,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             overrun
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        SHIFT,
        CAPTURE,
        HOLD
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] bit_cnt, bit_cnt_nxt;

    always_ff @(posedge clk) begin
        if (clear) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            data_out <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            if (state == CAPTURE) begin
                data_out <= sipo_q;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        busy          = 1'b1;
        sipo_clear_n  = 1'b1;
        sipo_shift_en = 1'b0;
        data_valid    = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = CLR;
                end
            end
            CLR: begin
                sipo_clear_n = 1'b0;
                bit_cnt_nxt  = '0;
                state_nxt    = SHIFT;
            end
            SHIFT: begin
                sipo_shift_en = 1'b1;
                // counter parks at LAST instead of wrapping
                if (bit_cnt == LAST) begin
                    state_nxt = CAPTURE;
                end else begin
                    bit_cnt_nxt = bit_cnt + 1'b1;
                end
            end
            CAPTURE: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                data_valid = 1'b1;
                if (data_ready) begin
                    state_nxt = start ? CLR : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef SIPO_CTRL_OVERRUN_EN
    logic overrun_q;
    logic start_ignored;

    // a start that cannot be honoured by the sequencer
    assign start_ignored = start && ((state == CLR) || (state == SHIFT) || (state == CAPTURE) ||
                                     ((state == HOLD) && !data_ready));

    always_ff @(posedge clk) begin
        if (clear) begin
            overrun_q <= 1'b0;
        end else if (start_ignored) begin
            overrun_q <= 1'b1;
        end
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: doc/sipo_ctrl.md
# sipo_ctrl

Sequencing controller for the WIDTH-bit serial-in/parallel-out shift register built from the team's positive-edge D flip-flops. On a start request it clears the shift chain, then enables exactly WIDTH shifts. It captures the chain's parallel outputs and presents the word on a valid/ready handshake to the downstream consumer. The serial data line goes directly to the shift chain; this block only owns timing and word capture.

## Interface
- WIDTH, 8, word length and shift count; legal range 2..64.

- clk  input  1  rising-edge clock shared with the shift chain.
- clear  input  1  synchronous, active-high reset.
- start  input  1  request to receive one word; sampled only in IDLE, or in HOLD during a transfer cycle.
- busy  output  1  high in every state except IDLE.
- sipo_clear_n  output  1  active-low clear to the shift-chain flops; low only in state CLR.
- sipo_shift_en  output  1  shift enable to the chain; high only in state SHIFT.
- sipo_q  input  WIDTH  parallel outputs of the shift chain.
- data_out  output  WIDTH  captured word; holds its value until the next capture.
- data_valid  output  1  high in HOLD.
- data_ready  input  1  consumer accept.
- overrun  output  1  sticky error flag (see Configuration).

## Operation
- Reset is synchronous and active-high. While clear is sampled high, the next state is IDLE.
- Reset values: busy=0, sipo_clear_n=1, sipo_shift_en=0, data_out=0, data_valid=0, overrun=0, bit counter=0.
- State machine: IDLE, CLR, SHIFT, CAPTURE, HOLD. All outputs are decoded from registered state; there are no combinational input-to-output paths.
- IDLE:
  - start=1 -> CLR.
  - Otherwise stay in IDLE.
- CLR: one cycle with sipo_clear_n=0; the counter loads 0. Next state is SHIFT.
- SHIFT:
  - sipo_shift_en=1; the counter increments each cycle.
  - When counter==WIDTH-1, go to CAPTURE. This gives exactly WIDTH shift cycles.
  - The counter is ceil(log2(WIDTH)) bits wide and never wraps.
- CAPTURE: data_out <= sipo_q, latched at the end of this cycle. Next state is HOLD.
- HOLD: data_valid=1.
  - Transfer occurs on a cycle with data_valid&data_ready.
  - Transfer with start=1 -> CLR (back-to-back words, no IDLE gap).
  - Transfer with start=0 -> IDLE.
  - No transfer -> stay in HOLD; data_out stays stable.
- start in CLR, SHIFT or CAPTURE, or in HOLD without a transfer, is ignored for sequencing.
- data_ready outside HOLD is ignored.
- Sender obligation: bit k (k=0 first) is presented on the chain's serial input during the k-th SHIFT cycle. The first-shifted bit ends in the chain's far stage; bit order inside the word is defined by the chain wiring, not by this block.

## Timing
- Cycle t is the cycle in which start is sampled high in IDLE.
- CLR occupies t+1.
- SHIFT occupies t+2 .. t+WIDTH+1.
- CAPTURE occupies t+WIDTH+2.
- data_valid=1 from t+WIDTH+3.
- Minimum start-to-valid latency is WIDTH+3 cycles.
- A transfer at cycle h with start=1 puts CLR at h+1. Sustained throughput is one word per WIDTH+3 cycles when data_ready is held high.
- busy rises at t+1 and falls on the cycle after a transfer without a chained start.
- Reset mid-operation (clear=1 in any state):
  - The next cycle is IDLE with reset values; data_out returns to 0 and any pending word is discarded.
  - The shift chain is not cleared by this block during reset. The next frame's CLR cycle clears it.
- clear and start high together: clear wins.

## Configuration
- Macro SIPO_CTRL_OVERRUN_EN.
- Defined:
  - overrun sets to 1 on any cycle where start=1 in CLR, SHIFT or CAPTURE, or in HOLD without a transfer.
  - It stays 1 until clear.
  - Sequencing is unaffected.
- Not defined: overrun is constant 0 and the detection logic is absent.

## Test plan
- Reset check (WIDTH=8): clear=1 for 2 cycles from an arbitrary state -> all outputs at reset values; IDLE on the cycle after clear drops.
- Single word (WIDTH=8): pulse start; serial bits 1,0,1,1,0,0,1,0 into the chain during the SHIFT cycles; data_ready=1 -> sipo_clear_n low exactly at t+1; sipo_shift_en high for exactly 8 cycles; data_valid at t+11 with data_out matching the chain contents; IDLE at t+12.
- Backpressure: data_ready=0 for 5 cycles in HOLD -> data_valid and data_out stable for all 5 cycles; transfer on the 6th; busy falls the cycle after.
- Back-to-back: start=1 and data_ready=1 in the transfer cycle -> CLR on the next cycle; the second word (0xA5) captured correctly; no IDLE cycle between frames.
- Reset mid-SHIFT: assert clear on the 4th SHIFT cycle -> IDLE the next cycle; data_out=0; a new start then completes normally with the correct word.
- Overrun (macro defined): start=1 during SHIFT -> overrun=1 the next cycle; the in-flight word still completes correctly; overrun stays 1 until clear. With the macro undefined, the same stimulus gives overrun=0.
